// File: rtl/div_pkg.sv
// Shared definitions for the divider requester: FSM state encoding, the
// captured result record and a width helper used by the watchdog.
package div_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        RESP
    } div_state_e;

    typedef struct packed {
        logic [DIV_W-1:0] quotient;
        logic [DIV_W-1:0] remainder;
        logic             div_by_zero;
        logic             timeout;
    } div_result_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/div_watchdog.sv
// Saturating cycle counter guarding the divider handshake; expired marks the
// LIMIT-th enabled cycle so the caller can leave on that clock edge.
module div_watchdog
    import div_pkg::*;
#(
    parameter int LIMIT = 20,
    parameter int CNT_W = clog2(LIMIT + 1)
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != MAX) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/div_requester.sv
// Client-side sequencer for the bitslice divider: accepts operand pairs, issues
// one Req pulse, waits for a fresh Done (or timeout) and returns the result.
module div_requester
    import div_pkg::*;
#(
    parameter int OPERAND_W      = DIV_W,
    parameter int TIMEOUT_CYCLES = 2 * OPERAND_W + 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [OPERAND_W-1:0] InDividend,
    input  logic [OPERAND_W-1:0] InDivisor,
    output logic                 Req,
    output logic [OPERAND_W-1:0] Dividend,
    output logic [OPERAND_W-1:0] Divisor,
    input  logic                 Done,
    input  logic [OPERAND_W-1:0] Quotient,
    input  logic [OPERAND_W-1:0] Remainder,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [OPERAND_W-1:0] OutQuotient,
    output logic [OPERAND_W-1:0] OutRemainder,
    output logic                 OutDivByZero,
    output logic                 OutTimeout,
    output logic                 Busy
);

    div_state_e  state;
    div_state_e  state_next;
    div_result_t result;
    logic        accept;
    logic        wd_expired;

    assign accept = (state == IDLE) && InValid;

    div_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (accept),
        .enable  ((state == ARM) || (state == WAIT)),
        .expired (wd_expired)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (InValid) state_next = (InDivisor == '0) ? RESP : ISSUE;
            ISSUE:   state_next = ARM;
            ARM:     state_next = WAIT;   // Done here may be left over from the previous op
            WAIT:    if (Done || wd_expired) state_next = RESP;
            RESP:    if (OutReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        InReady  = 1'b0;
        Req      = 1'b0;
        OutValid = 1'b0;
        Busy     = 1'b1;
        case (state)
            IDLE: begin
                InReady = 1'b1;
                Busy    = 1'b0;
            end
            ISSUE:   Req      = 1'b1;
            RESP:    OutValid = 1'b1;
            default: ;
        endcase
    end

    // Operands drive the datapath directly, so they move only on acceptance.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Dividend <= '0;
            Divisor  <= '0;
        end else if (accept) begin
            Dividend <= InDividend;
            Divisor  <= InDivisor;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            result <= '0;
        end else if (accept && InDivisor == '0) begin
            result.quotient    <= '1;
            result.remainder   <= InDividend;
            result.div_by_zero <= 1'b1;
            result.timeout     <= 1'b0;
        end else if (state == WAIT && Done) begin
            result.quotient    <= Quotient;
            result.remainder   <= Remainder;
            result.div_by_zero <= 1'b0;
            result.timeout     <= 1'b0;
        end else if (state == WAIT && wd_expired) begin
            result.quotient    <= '1;
            result.remainder   <= '0;
            result.div_by_zero <= 1'b0;
            result.timeout     <= 1'b1;
        end
    end

    assign OutQuotient  = result.quotient;
    assign OutRemainder = result.remainder;
    assign OutDivByZero = result.div_by_zero;
    assign OutTimeout   = result.timeout;

endmodule

// File: tb/tb_div_requester.sv
// Self-checking bench for div_requester: behavioural divider with programmable
// latency, arithmetic reference model and per-scenario checking tasks.
module tb_div_requester;

    localparam int W  = 8;
    localparam int TO = 2 * W + 4;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [W-1:0] InDividend = '0;
    logic [W-1:0] InDivisor = '0;
    logic         Req;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Done = 1'b0;
    logic [W-1:0] Quotient = '0;
    logic [W-1:0] Remainder = '0;
    logic         OutValid;
    logic         OutReady = 1'b0;
    logic [W-1:0] OutQuotient;
    logic [W-1:0] OutRemainder;
    logic         OutDivByZero;
    logic         OutTimeout;
    logic         Busy;

    int checks = 0;
    int failures = 0;

    div_requester dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .InValid      (InValid),
        .InReady      (InReady),
        .InDividend   (InDividend),
        .InDivisor    (InDivisor),
        .Req          (Req),
        .Dividend     (Dividend),
        .Divisor      (Divisor),
        .Done         (Done),
        .Quotient     (Quotient),
        .Remainder    (Remainder),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutQuotient  (OutQuotient),
        .OutRemainder (OutRemainder),
        .OutDivByZero (OutDivByZero),
        .OutTimeout   (OutTimeout),
        .Busy         (Busy)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         tmo;
    } exp_t;

    function automatic exp_t ref_result(input logic [W-1:0] a, input logic [W-1:0] b, input bit hang);
        exp_t e;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dbz = 1'b1; e.tmo = 1'b0;
        end else if (hang) begin
            e.q = '1; e.r = '0; e.dbz = 1'b0; e.tmo = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.tmo = 1'b0;
        end
        return e;
    endfunction

    // Divider stand-in: Done stays high after a result until the cycle after the
    // next Req has been seen, so the requester always meets a stale Done once.
    int           dv_lat = 1;
    bit           dv_hang = 1'b0;
    int           dv_cnt = 0;
    logic [W-1:0] dv_a = '0;
    logic [W-1:0] dv_b = '0;

    always @(posedge Clock) begin
        if (Req === 1'b1) begin
            dv_cnt <= dv_lat;
            dv_a   <= Dividend;
            dv_b   <= Divisor;
        end else if (dv_cnt != 0) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1 && !dv_hang) begin
                Done      <= 1'b1;
                Quotient  <= dv_a / dv_b;
                Remainder <= dv_a % dv_b;
            end else begin
                Done <= 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit expired");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Presents one pair from IDLE and runs until OutValid, checking latency and result.
    task automatic issue_and_collect(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input int lat, input bit hang, input string tag,
                                     output exp_t e);
        int n;
        int reqs;
        int exp_n;
        bit hold_err;
        bit ready_err;
        e = ref_result(a, b, hang);
        exp_n = hang ? TO + 1 : lat + 2;
        dv_lat = lat;
        dv_hang = hang;
        checks++;
        if (InReady !== 1'b1) begin
            failures++; $display("FAIL %s in_ready_idle: got %b expected 1", tag, InReady);
        end
        InValid = 1'b1; InDividend = a; InDivisor = b;
        tick();
        InValid = 1'b0; InDividend = W'($urandom); InDivisor = W'($urandom);
        checks++;
        if (Dividend !== a || Divisor !== b) begin
            failures++; $display("FAIL %s operands_latched: got %0d/%0d expected %0d/%0d", tag, Dividend, Divisor, a, b);
        end
        reqs = (Req === 1'b1) ? 1 : 0;
        n = 0; hold_err = 1'b0; ready_err = 1'b0;
        while (OutValid !== 1'b1 && n < 4 * TO) begin
            tick();
            n++;
            if (Req === 1'b1) reqs++;
            if (Dividend !== a || Divisor !== b) hold_err = 1'b1;
            if (InReady !== 1'b0 || Busy !== 1'b1) ready_err = 1'b1;
        end
        checks++;
        if (OutValid !== 1'b1) begin
            failures++; $display("FAIL %s out_valid: got %b expected 1 within %0d cycles", tag, OutValid, 4 * TO);
        end
        checks++;
        if (reqs != ((b != 0) ? 1 : 0)) begin
            failures++; $display("FAIL %s req_pulses: got %0d expected %0d", tag, reqs, (b != 0) ? 1 : 0);
        end
        checks++;
        if (b != 0 && n != exp_n) begin
            failures++; $display("FAIL %s latency: got %0d expected %0d", tag, n, exp_n);
        end else if (b == 0 && n > 1) begin
            failures++; $display("FAIL %s dbz_latency: got %0d expected <= 1", tag, n);
        end
        checks++;
        if (hold_err || ready_err) begin
            failures++; $display("FAIL %s hold_during_op: operand_err=%b ready_busy_err=%b expected 0/0", tag, hold_err, ready_err);
        end
        checks++;
        if (OutQuotient !== e.q || OutRemainder !== e.r || OutDivByZero !== e.dbz || OutTimeout !== e.tmo) begin
            failures++;
            $display("FAIL %s result: got q=%0d r=%0d dbz=%b to=%b expected q=%0d r=%0d dbz=%b to=%b",
                     tag, OutQuotient, OutRemainder, OutDivByZero, OutTimeout, e.q, e.r, e.dbz, e.tmo);
        end
    endtask

    // Stalls the consumer for 'hold' cycles, then takes the result; optionally
    // presents the next pair in the same cycle to confirm there is no bypass.
    task automatic release_result(input exp_t e, input int hold, input bit next_valid,
                                  input logic [W-1:0] na, input logic [W-1:0] nb, input string tag);
        bit stable_err;
        stable_err = 1'b0;
        for (int i = 0; i < hold; i++) begin
            OutReady = 1'b0;
            tick();
            if (OutValid !== 1'b1 || OutQuotient !== e.q || OutRemainder !== e.r ||
                OutDivByZero !== e.dbz || OutTimeout !== e.tmo || InReady !== 1'b0)
                stable_err = 1'b1;
        end
        checks++;
        if (stable_err) begin
            failures++; $display("FAIL %s resp_stable: got unstable=1 expected 0 over %0d cycles", tag, hold);
        end
        OutReady = 1'b1;
        if (next_valid) begin
            InValid = 1'b1; InDividend = na; InDivisor = nb;
        end
        tick();
        OutReady = 1'b0;
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || Busy !== 1'b0 || Req !== 1'b0) begin
            failures++;
            $display("FAIL %s back_to_idle: got valid=%b ready=%b busy=%b req=%b expected 0 1 0 0",
                     tag, OutValid, InReady, Busy, Req);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; InValid = 1'b1; InDividend = 8'd33; InDivisor = 8'd5;
        tick();
        tick();
        checks++;
        if (InReady !== 1'b1 || Req !== 1'b0 || OutValid !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got ready=%b req=%b valid=%b busy=%b expected 1 0 0 0", InReady, Req, OutValid, Busy);
        end
        checks++;
        if (Dividend !== '0 || Divisor !== '0 || OutQuotient !== '0 || OutRemainder !== '0 ||
            OutDivByZero !== 1'b0 || OutTimeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: got %0d %0d %0d %0d %b %b expected all 0",
                     Dividend, Divisor, OutQuotient, OutRemainder, OutDivByZero, OutTimeout);
        end
        InValid = 1'b0;
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        exp_t e;
        issue_and_collect(8'd100, 8'd7, 5, 1'b0, "basic_100_7", e);
        release_result(e, 0, 1'b0, '0, '0, "basic_100_7");
    endtask

    task automatic test_div_by_zero();
        exp_t e;
        issue_and_collect(8'd100, 8'd0, 3, 1'b0, "dbz_100_0", e);
        release_result(e, 1, 1'b0, '0, '0, "dbz_100_0");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        issue_and_collect(8'd200, 8'd3, 3, 1'b0, "b2b_200_3", e);
        release_result(e, 0, 1'b1, 8'd9, 8'd4, "b2b_200_3");
        issue_and_collect(8'd9, 8'd4, 4, 1'b0, "b2b_9_4", e);
        release_result(e, 0, 1'b0, '0, '0, "b2b_9_4");
    endtask

    task automatic test_stall();
        exp_t e;
        issue_and_collect(8'd123, 8'd10, 2, 1'b0, "stall_123_10", e);
        release_result(e, 5, 1'b0, '0, '0, "stall_123_10");
    endtask

    task automatic test_timeout();
        exp_t e;
        issue_and_collect(8'd77, 8'd5, 1, 1'b1, "timeout_77_5", e);
        release_result(e, 0, 1'b0, '0, '0, "timeout_77_5");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int stray;
        dv_lat = 10; dv_hang = 1'b0;
        InValid = 1'b1; InDividend = 8'd50; InDivisor = 8'd6;
        tick();
        InValid = 1'b0;
        checks++;
        if (Req !== 1'b1) begin
            failures++; $display("FAIL rst_issue_req: got %b expected 1", Req);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (Req !== 1'b0 || InReady !== 1'b1) begin
            failures++; $display("FAIL rst_issue_abort: got req=%b ready=%b expected 0 1", Req, InReady);
        end
        InValid = 1'b1; InDividend = 8'd50; InDivisor = 8'd6;
        tick();
        InValid = 1'b0;
        tick();
        tick();
        checks++;
        if (Busy !== 1'b1 || OutValid !== 1'b0) begin
            failures++; $display("FAIL rst_wait_state: got busy=%b valid=%b expected 1 0", Busy, OutValid);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || Busy !== 1'b0 || Req !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_abort: got ready=%b valid=%b busy=%b req=%b expected 1 0 0 0", InReady, OutValid, Busy, Req);
        end
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (OutValid === 1'b1 || Req === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++; $display("FAIL rst_no_result: got %0d stray cycles expected 0", stray);
        end
        issue_and_collect(8'd15, 8'd4, 2, 1'b0, "rst_15_4", e);
        release_result(e, 0, 1'b0, '0, '0, "rst_15_4");
    endtask

    task automatic test_random();
        exp_t e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 255));
            issue_and_collect(a, b, $urandom_range(1, 8), 1'b0, $sformatf("rand%0d", i), e);
            release_result(e, $urandom_range(0, 3), 1'b0, '0, '0, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
